// File: rtl/audio_pkg.sv
// Shared audio sample-path definitions: default sample width, midscale and the PWM output FSM states.
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 8;
  localparam int AUDIO_PWM_REPEAT   = 4;
  localparam logic [AUDIO_SAMPLE_WIDTH-1:0] MIDSCALE =
    AUDIO_SAMPLE_WIDTH'(1) << (AUDIO_SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/audio_pwm_counter.sv
// PWM phase counter plus per-sample repeat counter; flags the last cycle of each period and of each frame.
module audio_pwm_counter #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int PWM_REPEAT   = 4
) (
  input  logic                    inputClock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    enable,
  output logic [SAMPLE_WIDTH-1:0] pwm_count,
  output logic                    wrap,
  output logic                    boundary
);

  localparam int REP_W = (PWM_REPEAT > 1) ? $clog2(PWM_REPEAT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(PWM_REPEAT - 1);

  logic [REP_W-1:0] repeat_count;

  assign wrap     = &pwm_count;
  assign boundary = wrap && (repeat_count == REP_LAST);

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_count    <= '0;
      repeat_count <= '0;
    end else if (clear) begin
      pwm_count    <= '0;
      repeat_count <= '0;
    end else if (enable) begin
      pwm_count <= pwm_count + 1'b1;
      if (wrap) begin
        repeat_count <= (repeat_count == REP_LAST) ? '0 : repeat_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_pwm_output.sv
// Sample sink: one-entry buffered valid/ready input, frame-paced playback and PWM compare.
// Optional soft-start ramp is built when AUDIO_PWM_SOFTSTART_EN is defined.
module audio_pwm_output
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int PWM_REPEAT   = AUDIO_PWM_REPEAT
) (
  input  logic                    inputClock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] inputSample,
  input  logic                    sampleValid,
  output logic                    sampleReady,
  output logic                    pwmOut,
  output logic                    frameStrobe,
  output logic                    underrun,
  output pwm_state_t              fsm_state
);

  localparam logic [SAMPLE_WIDTH-1:0] MID = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

  // Handshake: a sample transfers on a rising edge where sampleValid && sampleReady;
  // sampleReady is high exactly while the one-entry buffer is empty, and upstream
  // must hold inputSample stable until it is taken.
  pwm_state_t              state_q;
  logic                    buffer_full;
  logic [SAMPLE_WIDTH-1:0] buffer_sample;
  logic [SAMPLE_WIDTH-1:0] active_sample;
  logic [SAMPLE_WIDTH-1:0] effective_sample;
  logic [SAMPLE_WIDTH-1:0] pwm_count;
  logic                    wrap;
  logic                    boundary;
  logic                    running;
  logic                    accept;
  logic                    boundary_cycle;
  logic                    load_cycle;
  logic                    bypass;
  logic                    buffer_full_next;

  assign running        = (state_q == RUN);
  assign accept         = sampleValid && sampleReady;
  assign boundary_cycle = running && boundary;
  assign load_cycle     = ((state_q == IDLE) && enable && buffer_full) ||
                          (boundary_cycle && enable);
  // An empty buffer at a boundary can still be served by a same-edge transfer.
  assign bypass           = boundary_cycle && enable && !buffer_full && accept;
  assign buffer_full_next = load_cycle ? 1'b0 : (buffer_full || accept);

  assign frameStrobe = boundary_cycle;
  assign underrun    = boundary_cycle && enable && !buffer_full && !accept;
  assign fsm_state   = state_q;

  audio_pwm_counter #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .PWM_REPEAT   (PWM_REPEAT)
  ) u_counter (
    .inputClock (inputClock),
    .reset_n    (reset_n),
    .clear      (!running),
    .enable     (running),
    .pwm_count  (pwm_count),
    .wrap       (wrap),
    .boundary   (boundary)
  );

`ifdef AUDIO_PWM_SOFTSTART_EN
  logic [SAMPLE_WIDTH-1:0] ramp_level;

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      ramp_level <= '0;
    end else if (state_q == IDLE) begin
      ramp_level <= '0;
    end else if (running && wrap && !(&ramp_level)) begin
      ramp_level <= ramp_level + 1'b1;
    end
  end

  assign effective_sample = (active_sample < ramp_level) ? active_sample : ramp_level;
`else
  assign effective_sample = active_sample;
`endif

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      buffer_full   <= 1'b0;
      buffer_sample <= '0;
      active_sample <= MID;
      sampleReady   <= 1'b1;
      pwmOut        <= 1'b0;
    end else begin
      pwmOut      <= running && (pwm_count < effective_sample);
      buffer_full <= buffer_full_next;
      sampleReady <= !buffer_full_next;
      if (accept && !bypass) begin
        buffer_sample <= inputSample;
      end
      case (state_q)
        IDLE: begin
          if (enable && buffer_full) begin
            state_q       <= RUN;
            active_sample <= buffer_sample;
          end
        end
        RUN: begin
          if (boundary) begin
            if (!enable) begin
              state_q <= DRAIN;
            end else if (buffer_full) begin
              active_sample <= buffer_sample;
            end else if (accept) begin
              active_sample <= inputSample;
            end
          end
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_pwm_output.sv
// Randomized bench for audio_pwm_output against a cycle-indexed playback model.
`timescale 1ns/1ps
module tb_audio_pwm_output;
  import audio_pkg::*;

  localparam int SW     = 8;
  localparam int REP    = 4;
  localparam int PERIOD = 256;
  localparam int FRAME  = PERIOD * REP;
  localparam int MID    = 128;

  logic          input_clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] input_sample = '0;
  logic          sample_ready;
  logic          pwm_out;
  logic          frame_strobe;
  logic          underrun;
  pwm_state_t    fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int ur_seen  = 0;

  // clock / reset
  always #5 input_clock = ~input_clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  audio_pwm_output #(
    .SAMPLE_WIDTH (SW),
    .PWM_REPEAT   (REP)
  ) dut (
    .inputClock  (input_clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .inputSample (input_sample),
    .sampleValid (sample_valid),
    .sampleReady (sample_ready),
    .pwmOut      (pwm_out),
    .frameStrobe (frame_strobe),
    .underrun    (underrun),
    .fsm_state   (fsm_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: exp_q holds accepted-but-not-yet-playing samples
  logic [SW-1:0] exp_q[$];
  bit m_run, m_drain;
  int m_rc;    // cycles spent in RUN since playback started
  int m_play;  // sample currently being played

  function automatic int eff_level(input int s, input int k);
`ifdef AUDIO_PWM_SOFTSTART_EN
    int r;
    r = (k > 255) ? 255 : k;
    return (s < r) ? s : r;
`else
    return s + 0 * k;
`endif
  endfunction

  always @(negedge input_clock) begin : model
    bit bnd, xfer, exp_pwm;
    int ph;
    pwm_state_t exp_st;
    if (!reset_n) begin
      exp_q.delete();
      m_run = 0; m_drain = 0; m_rc = 0; m_play = MID;
    end else begin
      ph      = m_rc % PERIOD;
      bnd     = m_run && (m_rc % FRAME == FRAME - 1);
      xfer    = sample_valid && (exp_q.size() == 0);
      exp_pwm = m_run && (ph != 0) && ((ph - 1) < eff_level(m_play, m_rc / PERIOD));
      exp_st  = m_run ? RUN : (m_drain ? DRAIN : IDLE);
      check_eq("state", fsm_state, exp_st);
      check_eq("ready", sample_ready, exp_q.size() == 0);
      check_eq("strobe", frame_strobe, bnd);
      check_eq("underrun", underrun, bnd && enable && (exp_q.size() == 0) && !xfer);
      check_eq("pwm", pwm_out, exp_pwm);
      if (underrun) ur_seen++;
      if (m_drain) begin
        m_drain = 0;
        if (xfer) exp_q.push_back(input_sample);
      end else if (!m_run) begin
        if (enable && exp_q.size() > 0) begin
          m_play = exp_q.pop_front();
          m_run = 1; m_rc = 0;
        end else if (xfer) exp_q.push_back(input_sample);
      end else if (bnd && !enable) begin
        m_run = 0; m_drain = 1;
        if (xfer) exp_q.push_back(input_sample);
      end else begin
        m_rc++;
        if (bnd) begin
          if (exp_q.size() > 0) m_play = exp_q.pop_front();
          else if (xfer) m_play = input_sample;
        end else if (xfer) exp_q.push_back(input_sample);
      end
    end
  end

  // driver tasks
  task automatic send_sample(input logic [SW-1:0] v);
    int waited;
    waited = 0;
    @(posedge input_clock); #1;
    sample_valid = 1'b1;
    input_sample = v;
    do begin
      @(negedge input_clock);
      waited++;
    end while (!sample_ready && waited < 3 * FRAME);
    check_eq("send_accepted", waited < 3 * FRAME, 1);
    @(posedge input_clock); #1;
    sample_valid = 1'b0;
    input_sample = SW'($urandom_range(0, 255));
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    do begin
      @(posedge input_clock); #1;
      n++;
    end while (!(m_run && (m_rc % FRAME == pos)) && n < 4 * FRAME);
    check_eq("wait_pos_reached", n < 4 * FRAME, 1);
  endtask

  task automatic measure_duty(output int highs);
    highs = 0;
    repeat (PERIOD) begin
      @(negedge input_clock);
      if (pwm_out) highs++;
    end
  endtask

  initial begin : stimulus
    int highs;
    repeat (3) @(posedge input_clock);
    #1;
    check_eq("rst_pwm", pwm_out, 0);
    check_eq("rst_ready", sample_ready, 1);
    check_eq("rst_strobe", frame_strobe, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_state", fsm_state, IDLE);
    reset_n = 1'b1;
    enable  = 1'b1;

    // enabled with no samples: stays idle, never underruns
    ur_seen = 0;
    repeat (600) @(posedge input_clock);
    #1;
    check_eq("idle_underruns", ur_seen, 0);
    check_eq("idle_state", fsm_state, IDLE);

    // steady 0x40 stream
    for (int i = 0; i < 4; i++) send_sample(8'h40);
    measure_duty(highs);
    check_eq("duty_40", highs, 64);

    // one 0x80 then starve: one load, three underruns, duty held at 128
    send_sample(8'h80);
    ur_seen = 0;
    repeat (4 * FRAME - PERIOD) @(negedge input_clock);
    measure_duty(highs);
    check_eq("starve_underruns", ur_seen, 3);
    check_eq("duty_80_held", highs, 128);

    // valid raised only in the boundary cycle itself
    wait_pos(FRAME - 1);
    ur_seen = 0;
    sample_valid = 1'b1;
    input_sample = 8'h33;
    @(posedge input_clock); #1;
    sample_valid = 1'b0;
    measure_duty(highs);
    check_eq("bypass_underruns", ur_seen, 0);
    check_eq("duty_33", highs, 8'h33);

    // random samples with random gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 1400)) @(posedge input_clock);
      send_sample(SW'($urandom_range(0, 255)));
    end

    // enable drop mid-frame with a buffered sample
    send_sample(8'hA5);
    send_sample(8'h5A);
    wait_pos(300);
    enable = 1'b0;
    repeat (FRAME) @(posedge input_clock);
    #1;
    check_eq("drain_state", fsm_state, IDLE);
    check_eq("drain_pwm", pwm_out, 0);
    check_eq("drain_buffer_kept", sample_ready, 0);
    enable = 1'b1;
    repeat (4) @(posedge input_clock);
    measure_duty(highs);
    check_eq("duty_5a_resumed", highs, 8'h5A);

    // reset in the middle of a frame
    wait_pos(700);
    reset_n = 1'b0;
    #2;
    check_eq("midrst_pwm", pwm_out, 0);
    check_eq("midrst_ready", sample_ready, 1);
    check_eq("midrst_strobe", frame_strobe, 0);
    check_eq("midrst_underrun", underrun, 0);
    check_eq("midrst_state", fsm_state, IDLE);
    @(posedge input_clock); #1;
    reset_n = 1'b1;
    send_sample(8'hC8);
    repeat (FRAME + 200) @(posedge input_clock);

`ifdef AUDIO_PWM_SOFTSTART_EN
    // full-scale input after a fresh start: duty ramps one step per period
    enable = 1'b0;
    repeat (FRAME + 10) @(posedge input_clock);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) send_sample(8'hFF);
    repeat (FRAME) @(posedge input_clock);
`endif

    repeat (10) @(posedge input_clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_pwm_output.md
# audio_pwm_output

Consumer end of the sample path: accepts 8-bit unsigned audio samples from the sine/tone generators over a valid/ready handshake and converts each to a 1-bit pulse-width-modulated stream for the board's RC-filtered audio pin. It owns the playback rate. Each sample is held for a fixed number of PWM periods, and a new sample is pulled only at frame boundaries, so upstream generators advance exactly once per output sample.

## Interface
- SAMPLE_WIDTH, 8: sample width; PWM period = 2^SAMPLE_WIDTH cycles.
- PWM_REPEAT, 4: PWM periods per sample (≥1); frame length = PWM_REPEAT × 2^SAMPLE_WIDTH cycles.
- inputClock  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; playback allowed.
- inputSample  in  SAMPLE_WIDTH  unsigned sample, midscale = 2^(SAMPLE_WIDTH-1).
- sampleValid  in  1  inputSample valid.
- sampleReady  out  1  one-entry buffer empty; transfer when valid && ready at rising edge.
- pwmOut  out  1  registered PWM stream.
- frameStrobe  out  1  one-cycle pulse on each sample-boundary cycle.
- underrun  out  1  one-cycle pulse when a boundary finds no sample.

## Operation
- Storage: bufferSample + bufferFull (1 entry), activeSample, pwmCount (SAMPLE_WIDTH bits, wraps), repeatCount (0..PWM_REPEAT-1).
- States: IDLE, RUN, DRAIN.
- IDLE: counters held at 0, pwmOut 0. Go to RUN when enable && bufferFull. On that edge activeSample <= bufferSample and the buffer empties.
- RUN: pwmCount increments every cycle. On wrap 255→0, repeatCount increments modulo PWM_REPEAT.
- Boundary cycle: pwmCount==2^SAMPLE_WIDTH-1 && repeatCount==PWM_REPEAT-1.
  - enable low at boundary → DRAIN.
  - Otherwise:
    - bufferFull: activeSample <= bufferSample; buffer empties.
    - Buffer empty but a transfer happens on that same edge: the incoming sample goes straight to activeSample, with no underrun.
    - No sample at all: activeSample is held and underrun pulses.
- DRAIN: one cycle. pwmOut 0, counters cleared, then IDLE. bufferFull is preserved.
- Compare: pwmOut <= (pwmCount < effectiveSample). 0 gives 0% duty; 255 gives 255/256 duty.
- Handshake: sampleReady = !bufferFull, driven from a register. A transfer is accepted in any state. Valid without ready has no effect; upstream must hold data.
- enable dropping mid-frame: the current frame completes first (clean pulse end).

## Timing
- Reset values: pwmOut 0, sampleReady 1, frameStrobe 0, underrun 0, state IDLE, activeSample midscale, counters 0.
- Start-up: the first accepted sample reaches IDLE→RUN one edge after acceptance (when enable is high). pwmOut first rises on the edge after pwmCount==0.
- Output shape: pwmOut is high for exactly effectiveSample consecutive cycles per period, lagging pwmCount by one cycle.
- Buffer refill: sampleReady rises the cycle after a boundary load. Upstream has the whole frame minus one cycle to refill.
- frameStrobe and underrun are asserted in the boundary cycle itself (combinational from registered state, masked to RUN).
- Reset mid-frame: all state returns to reset values immediately; buffered samples are lost.

## Configuration
- AUDIO_PWM_SOFTSTART_EN defined:
  - Adds a SAMPLE_WIDTH-bit rampLevel, cleared in IDLE.
  - rampLevel increments by 1 at every pwmCount wrap in RUN, saturating at 2^SAMPLE_WIDTH-1.
  - effectiveSample = min(activeSample, rampLevel), which suppresses the start-up pop.
- Undefined: effectiveSample = activeSample and no ramp logic is present.

## Structure
- Package audio_pkg: SAMPLE_WIDTH default, MIDSCALE constant, pwm_state_t enum {IDLE, RUN, DRAIN}. The generators share this package.
- Sub-module audio_pwm_counter: pwmCount/repeatCount with clear and enable inputs, plus wrap and boundary outputs. The top level holds the FSM, buffer, compare and soft-start.

## Test plan
- Reset, enable=1, no samples: stays IDLE, pwmOut 0, sampleReady 1, no underrun pulses.
- Send 0x40, then 0x40 continuously: pwmOut high 64 of every 256 cycles. frameStrobe every 1024 cycles; one accept per frame.
- Send 0x80 once, then stop: after the first frame, underrun pulses every 1024 cycles and duty stays 128/256.
- Buffer empty at a boundary, with valid asserted exactly on the boundary edge: that sample is used in the next frame and no underrun occurs.
- Drop enable mid-frame: pwmOut keeps the pattern until the boundary. DRAIN lasts 1 cycle, then IDLE with pwmOut 0. The buffered sample is retained and plays after re-enable.
- With AUDIO_PWM_SOFTSTART_EN, feed a constant 0xFF: duty in period k equals k/256 (k = 0,1,2,…) until it reaches 255.
